// File: rtl/multi_ch_fsm_controller.sv
// Per-channel IDLE/NORMAL/WARNING/FAULT controller with persistence debounce, worst-case
// aggregation and a saturating fault-event counter. Optional macro: FAULT_LATCH_EN (sticky FAULT).
module multi_ch_fsm_controller #(
    parameter int NUM_CH   = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [2*NUM_CH-1:0] temp_state,
    input  logic                fault_clear,
    output logic [2*NUM_CH-1:0] ch_state,
    output logic [1:0]          system_state,
    output logic                fault_any,
    output logic                state_change,
    output logic [CNT_W-1:0]    fault_count
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DEBOUNCE);

`ifdef FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_NORMAL  = 2'b01,
        ST_WARNING = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    // Committed state, debounce candidate and run length of one channel.
    typedef struct packed {
        state_t           st;
        state_t           cand;
        logic [RUN_W-1:0] run;
    } ch_t;

    ch_t              ch_q [NUM_CH];
    ch_t              ch_d [NUM_CH];
    logic [CNT_W-1:0] fault_count_q, fault_count_d;
    logic             commit_q, commit_d;
    logic             state_change_q, state_change_d;

    function automatic state_t legal_target(state_t s, state_t i);
        state_t t;
        case (s)
            ST_IDLE:  t = (i == ST_NORMAL || i == ST_WARNING) ? i : ST_IDLE;
            ST_FAULT: t = (i == ST_IDLE) ? ST_IDLE : ST_FAULT;
            default:  t = i;
        endcase
        return t;
    endfunction

    always_comb begin
        state_t           in_s;
        state_t           tgt;
        logic [RUN_W-1:0] run_len;
        logic             entry;
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        in_s          = ST_IDLE;
        tgt           = ST_IDLE;
        run_len       = '0;
        entry         = 1'b0;
        commit_d      = 1'b0;
        ch_d          = ch_q;
        for (int i = 0; i < NUM_CH; i++) begin
            in_s = state_t'(temp_state[2*i +: 2]);
            tgt  = legal_target(ch_q[i].st, in_s);
            if (LATCH && ch_q[i].st == ST_FAULT)
                tgt = (fault_clear && in_s == ST_IDLE) ? ST_IDLE : ST_FAULT;
            run_len = (tgt == ch_q[i].cand) ? ch_q[i].run + 1'b1 : RUN_W'(1);

            if (tgt == ch_q[i].st) begin
                ch_d[i].run = '0;
            end else if (tgt == ST_FAULT || (LATCH && ch_q[i].st == ST_FAULT)) begin
                // Fault entry and the acknowledged latched exit skip the debounce.
                ch_d[i].st  = tgt;
                ch_d[i].run = '0;
                commit_d    = 1'b1;
                if (tgt == ST_FAULT) entry = 1'b1;
            end else begin
                ch_d[i].cand = tgt;
                if (run_len >= RUN_DONE) begin
                    ch_d[i].st  = tgt;
                    ch_d[i].run = '0;
                    commit_d    = 1'b1;
                end else begin
                    ch_d[i].run = run_len;
                end
            end
        end

        fault_count_d = fault_count_q;
        if (entry && fault_count_q != '1) fault_count_d = fault_count_q + 1'b1;
        state_change_d = commit_q;

        if (!en) begin
            ch_d           = ch_q;
            commit_d       = 1'b0;
            fault_count_d  = fault_count_q;
            state_change_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            // NOTE: the channel array is small and its reset value is architectural, so it is reset.
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
            fault_count_q  <= '0;
            commit_q       <= 1'b0;
            state_change_q <= 1'b0;
        end else begin
            ch_q           <= ch_d;
            fault_count_q  <= fault_count_d;
            commit_q       <= commit_d;
            state_change_q <= state_change_d;
        end
    end

    always_comb begin
        ch_state     = '0;
        system_state = ST_IDLE;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_state[2*i +: 2] = ch_q[i].st;
            if (ch_q[i].st > system_state) system_state = ch_q[i].st;
        end
    end

    assign fault_any    = (system_state == ST_FAULT);
    assign state_change = state_change_q;
    assign fault_count  = fault_count_q;

endmodule

// File: doc/multi_ch_fsm_controller.md
# multi_ch_fsm_controller

Parametrised, multi-channel successor to the single-channel temperature FSM controller. It runs one IDLE/NORMAL/WARNING/FAULT state machine per channel, filters each channel's input with a persistence debounce, and escalates to FAULT immediately. It aggregates all channels into one worst-case system state and keeps a fault-event counter. It sits between the bank of temp analyzers and the system supervisor.

## Interface

- NUM_CH, 4, number of channels (≥1)
- DEBOUNCE, 3, consecutive sampling edges a requested transition must persist before commit (≥1)
- CNT_W, 8, width of fault_count
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  reset; synchronous, active-high
- en  input  1  advance enable; low freezes all state, counters and debounce
- temp_state  input  2*NUM_CH  per-channel temperature state, channel i at [2i+1:2i]
- fault_clear  input  1  fault acknowledge (used only with FAULT_LATCH_EN)
- ch_state  output  2*NUM_CH  per-channel registered state, same packing
- system_state  output  2  worst-case (numerically max) of all ch_state
- fault_any  output  1  system_state == FAULT
- state_change  output  1  one-cycle pulse after any channel commits a transition
- fault_count  output  CNT_W  saturating count of fault-entry edges

## Operation

- Encoding: IDLE=00, NORMAL=01, WARNING=10, FAULT=11.
- Per-channel legal target, T, derived from current state S and input I:
  - S=IDLE: T=I if I∈{NORMAL,WARNING}, else IDLE. I=FAULT is ignored from IDLE.
  - S=NORMAL or S=WARNING: T=I.
  - S=FAULT: T=IDLE if I=IDLE, else FAULT.
- Debounce per channel uses a candidate register C and a run counter R (width clog2(DEBOUNCE+1)):
  - T==S: R←0.
  - T≠S, T≠C: C←T, R←1.
  - T≠S, T==C: R←R+1.
  - Commit S←T and R←0 when the run length including the current edge reaches DEBOUNCE. DEBOUNCE=1 commits on the first edge.
- FAULT escalation bypasses debounce. NORMAL/WARNING with I=FAULT commits to FAULT on that same edge, and R←0.
- system_state = max over ch_state. It is combinational from the registers and adds no latency. fault_any is decoded from it.
- fault_count: +1 on each edge where ≥1 channel enters FAULT. It counts 1 even if several channels enter together. It saturates at 2^CNT_W−1 and is cleared only by reset.
- en=0: no state, C, R, or fault_count update; state_change←0. reset overrides en.

## Timing

- Reset (sync, at edge with reset=1): ch_state all IDLE, system_state=IDLE, fault_any=0, state_change=0, fault_count=0, all C=IDLE, all R=0.
- Latency:
  - A non-FAULT transition appears on ch_state at the DEBOUNCE-th consecutive edge sampling the same target.
  - FAULT entry appears at the 1st edge.
- state_change is registered. It is high for exactly the cycle following a commit edge, so it lags ch_state by one cycle.
- Boundaries:
  - Target changes mid-run: the run restarts at 1.
  - Input returns to S mid-run: the run is dropped.
  - reset mid-run: the run is cleared.
  - en low mid-run: the run is frozen and resumes when en returns high.
  - Simultaneous commits on several channels: all apply on the same edge, and state_change is a single pulse.

## Configuration

- FAULT_LATCH_EN defined:
  - FAULT is sticky. S=FAULT→IDLE only on an edge where fault_clear=1 and that channel's I=IDLE. This exit is immediate, with no debounce.
  - fault_clear with I≠IDLE is ignored for that channel.
  - While latched, T is held at FAULT.
- FAULT_LATCH_EN undefined:
  - FAULT→IDLE follows the debounced rule above.
  - fault_clear is ignored.

## Test plan

- Reset with NUM_CH=4, DEBOUNCE=3: all outputs zero. Hold reset with inputs at FAULT → ch_state stays 0x00 and fault_count stays 0.
- Ch0 input NORMAL for 3 edges → ch0=NORMAL at the 3rd edge, state_change pulses the next cycle, system_state=01. Input NORMAL for only 2 edges, then IDLE → no change.
- Ch1 in NORMAL, input FAULT → ch1=FAULT on the 1st edge, fault_any=1, fault_count=1. Ch2 in IDLE with input FAULT → stays IDLE.
- Ch0 and ch3 (both WARNING) enter FAULT on the same edge → fault_count +1 only. Drive fault_count to 255 → it stays 255.
- Ch0 input WARNING for 2 edges, en=0 for 5 cycles, en=1 for 1 edge → commits on that edge (run of 3).
- FAULT_LATCH_EN: ch1 in FAULT, input IDLE for 10 edges → stays FAULT. fault_clear=1 with input IDLE → IDLE next edge. Without the macro → IDLE after 3 edges.
